ps2_frame_receiver: RTL and testbench

// - PS/2 keyboard receive stage feeding the colour decoder. Runs on boardClk and

---
 rtl/ps2_frame_receiver.sv | 212 +++++++++++++++++++++
 tb/tb_ps2_frame_receiver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_receiver.sv
// PS/2 keyboard receive stage for the colour decoder.
// Synchronises and deglitches the PS/2 clock and data pins, then deframes
// 11-bit frames (start, 8 data bits LSB first, odd parity, stop). E0 and F0
// prefixes are folded into extCode_o/breakCode_o on a one-cycle code strobe.
//
// state | meaning
// IDLE  | bus idle, waiting for a falling edge with data low (start bit)
// RECV  | shifting in data, parity and stop bits; watchdog armed
// CHECK | one cycle to validate the frame and publish or fold the byte
module ps2_frame_receiver #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic       boardClk_i,
    input  logic       reset_i,
    input  logic       ps2Clk_i,
    input  logic       ps2Data_i,
    output logic [7:0] scanCode_o,
    output logic       breakCode_o,
    output logic       extCode_o,
    output logic       codeValid_o,
    output logic       frameErr_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [FLT_W-1:0] FLT_LOAD = FLT_W'(FILTER_LEN - 1);
    localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] BYTE_BREAK = 8'hF0;
    localparam logic [7:0] BYTE_EXT   = 8'hE0;

    logic [1:0]       clk_sync_q;
    logic [1:0]       dat_sync_q;
    logic             clk_s;
    logic             dat_s;

    logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
    logic             clk_filt_q, clk_filt_d;
    logic             clk_filt_dly_q;
    logic             fall;

    logic [1:0]       state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [9:0]       shift_q, shift_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             pend_brk_q, pend_brk_d;
    logic             pend_ext_q, pend_ext_d;
    logic [7:0]       scan_q, scan_d;
    logic             brk_q, brk_d;
    logic             ext_q, ext_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             frame_good;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];

    // Two-flop synchronisers; reset to the idle-high bus level.
    always_ff @(posedge boardClk_i or posedge reset_i) begin
        if (reset_i) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2Clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2Data_i};
        end
    end

    // Deglitch: the filtered clock follows only after FILTER_LEN consecutive differing samples.
    always_comb begin
        flt_cnt_d  = flt_cnt_q;
        clk_filt_d = clk_filt_q;
        if (clk_s == clk_filt_q) begin
            flt_cnt_d = FLT_LOAD;
        end else if (flt_cnt_q == '0) begin
            clk_filt_d = clk_s;
            flt_cnt_d  = FLT_LOAD;
        end else begin
            flt_cnt_d = flt_cnt_q - FLT_W'(1);
        end
    end

    // Filter state and the delayed copy used for falling-edge detection.
    always_ff @(posedge boardClk_i or posedge reset_i) begin
        if (reset_i) begin
            flt_cnt_q      <= FLT_LOAD;
            clk_filt_q     <= 1'b1;
            clk_filt_dly_q <= 1'b1;
        end else begin
            flt_cnt_q      <= flt_cnt_d;
            clk_filt_q     <= clk_filt_d;
            clk_filt_dly_q <= clk_filt_q;
        end
    end

    assign fall = clk_filt_dly_q & ~clk_filt_q;

    // After ten shifts: [7:0] data, [8] parity, [9] stop.
    assign frame_good = (^shift_q[8:0]) & shift_q[9];

    // Deframing FSM, watchdog and prefix folding.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        wd_d       = wd_q;
        pend_brk_d = pend_brk_q;
        pend_ext_d = pend_ext_q;
        scan_d     = scan_q;
        brk_d      = brk_q;
        ext_d      = ext_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                wd_d = WD_LOAD;
                if (fall && !dat_s) begin
                    state_d   = RECV;
                    bit_cnt_d = 4'd1;
                    shift_d   = '0;
                end
            end
            RECV: begin
                if (fall) begin
                    shift_d   = {dat_s, shift_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    wd_d      = WD_LOAD;
                    if (bit_cnt_q == 4'd10) begin
                        state_d = CHECK;
                    end
                end else if (wd_q == '0) begin
                    state_d    = IDLE;
                    bit_cnt_d  = 4'd0;
                    err_d      = 1'b1;
                    pend_brk_d = 1'b0;
                    pend_ext_d = 1'b0;
                end else begin
                    wd_d = wd_q - WD_W'(1);
                end
            end
            CHECK: begin
                // A fall seen here cannot be a real start bit, so it is not acted on.
                state_d   = IDLE;
                bit_cnt_d = 4'd0;
                if (frame_good) begin
                    if (shift_q[7:0] == BYTE_BREAK) begin
                        pend_brk_d = 1'b1;
                    end else if (shift_q[7:0] == BYTE_EXT) begin
                        pend_ext_d = 1'b1;
                    end else begin
                        scan_d     = shift_q[7:0];
                        brk_d      = pend_brk_q;
                        ext_d      = pend_ext_q;
                        valid_d    = 1'b1;
                        pend_brk_d = 1'b0;
                        pend_ext_d = 1'b0;
                    end
                end else begin
                    err_d      = 1'b1;
                    pend_brk_d = 1'b0;
                    pend_ext_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = 4'd0;
            end
        endcase
    end

    // FSM and output registers; reset discards any partial frame.
    always_ff @(posedge boardClk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '0;
            wd_q       <= WD_LOAD;
            pend_brk_q <= 1'b0;
            pend_ext_q <= 1'b0;
            scan_q     <= 8'h00;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            wd_q       <= wd_d;
            pend_brk_q <= pend_brk_d;
            pend_ext_q <= pend_ext_d;
            scan_q     <= scan_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign scanCode_o  = scan_q;
    assign breakCode_o = brk_q;
    assign extCode_o   = ext_q;
    assign codeValid_o = valid_q;
    assign frameErr_o  = err_q;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Bench for ps2_frame_receiver: drives PS/2 frames at a shortened bus period,
// predicts strobes with a frame-level model and checks every cycle.
module tb_ps2_frame_receiver;

    localparam int FL   = 8;
    localparam int TO   = 400;
    localparam int HALF = 40;
    localparam int GAP  = 60;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2c;
    logic       ps2d;
    logic [7:0] scanCode;
    logic       breakCode;
    logic       extCode;
    logic       codeValid;
    logic       frameErr;

    ps2_frame_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .boardClk_i (clk),
        .reset_i    (rst),
        .ps2Clk_i   (ps2c),
        .ps2Data_i  (ps2d),
        .scanCode_o (scanCode),
        .breakCode_o(breakCode),
        .extCode_o  (extCode),
        .codeValid_o(codeValid),
        .frameErr_o (frameErr)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        bit         brk;
        bit         ext;
        int         lo;
        int         hi;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] m_scan = 8'h00;
    bit         m_brk  = 1'b0;
    bit         m_ext  = 1'b0;
    bit         m_pbrk = 1'b0;
    bit         m_pext = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Frame-level model: decide what a completed frame must produce.
    task automatic model_frame(input logic [7:0] b, input bit par, input bit stop, input int fall_cyc);
        ev_t ev;
        bit  good;
        int  ones;
        ones = 0;
        for (int k = 0; k < 8; k++) ones += int'(b[k]);
        ones += int'(par);
        good = ((ones % 2) == 1) && stop;
        ev.lo = fall_cyc + 5;
        ev.hi = fall_cyc + 30;
        if (!good) begin
            ev.is_err = 1'b1; ev.code = 8'h00; ev.brk = 1'b0; ev.ext = 1'b0;
            exp_q.push_back(ev);
            m_pbrk = 1'b0; m_pext = 1'b0;
        end else if (b == 8'hF0) begin
            m_pbrk = 1'b1;
        end else if (b == 8'hE0) begin
            m_pext = 1'b1;
        end else begin
            ev.is_err = 1'b0; ev.code = b; ev.brk = m_pbrk; ev.ext = m_pext;
            exp_q.push_back(ev);
            m_pbrk = 1'b0; m_pext = 1'b0;
        end
    endtask

    task automatic model_timeout(input int fall_cyc);
        ev_t ev;
        ev.is_err = 1'b1; ev.code = 8'h00; ev.brk = 1'b0; ev.ext = 1'b0;
        ev.lo = fall_cyc + TO;
        ev.hi = fall_cyc + TO + 40;
        exp_q.push_back(ev);
        m_pbrk = 1'b0; m_pext = 1'b0;
    endtask

    // Sends the first nbits of a frame; data changes mid-high, optional clock glitch.
    task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop,
                              input int nbits, input int glitch_bit, input bit expect_to);
        logic [10:0] bits;
        bits = {stop, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            repeat (HALF / 2) @(negedge clk);
            if (i == glitch_bit) begin
                ps2c = 1'b0;
                repeat (3) @(negedge clk);
                ps2c = 1'b1;
            end
            ps2d = bits[i];
            repeat (HALF / 2) @(negedge clk);
            ps2c = 1'b0;
            if (i == 10) model_frame(b, bits[9], bits[10], cyc);
            if (expect_to && i == nbits - 1) model_timeout(cyc);
            repeat (HALF) @(negedge clk);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        ps2c = 1'b1;
        ps2d = 1'b1;
        exp_q.delete();
        m_scan = 8'h00; m_brk = 1'b0; m_ext = 1'b0; m_pbrk = 1'b0; m_pext = 1'b0;
        @(negedge clk);
        check("reset_scan", 32'(scanCode), 32'h00);
        check("reset_brk", 32'(breakCode), 32'h0);
        check("reset_ext", 32'(extCode), 32'h0);
        check("reset_valid", 32'(codeValid), 32'h0);
        check("reset_err", 32'(frameErr), 32'h0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic expect_outputs(input string name, input logic [7:0] s, input bit b, input bit e);
        check({name, "_scan"}, 32'(scanCode), 32'(s));
        check({name, "_brk"}, 32'(breakCode), 32'(b));
        check({name, "_ext"}, 32'(extCode), 32'(e));
    endtask

    // Per-cycle compare against the model's expected strobes and held outputs.
    initial begin
        ev_t ev;
        forever begin
            @(posedge clk);
            #1;
            check("valid_err_exclusive", 32'(codeValid & frameErr), 32'h0);
            if (codeValid || frameErr) begin
                check("strobe_expected", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    ev = exp_q.pop_front();
                    check("strobe_kind_err", 32'(frameErr), 32'(ev.is_err));
                    check("strobe_window", 32'(cyc >= ev.lo && cyc <= ev.hi), 32'h1);
                    if (!ev.is_err) begin
                        m_scan = ev.code;
                        m_brk  = ev.brk;
                        m_ext  = ev.ext;
                    end
                end
            end else if (exp_q.size() != 0 && cyc > exp_q[0].hi) begin
                check("strobe_by_deadline", 32'(cyc <= exp_q[0].hi), 32'h1);
                void'(exp_q.pop_front());
            end
            check("hold_scan", 32'(scanCode), 32'(m_scan));
            check("hold_brk", 32'(breakCode), 32'(m_brk));
            check("hold_ext", 32'(extCode), 32'(m_ext));
        end
    end

    initial begin
        logic [7:0] b;
        int         r;
        int         gb;
        rst  = 1'b1;
        ps2c = 1'b1;
        ps2d = 1'b1;
        repeat (5) @(negedge clk);
        expect_outputs("por", 8'h00, 1'b0, 1'b0);
        check("por_valid", 32'(codeValid), 32'h0);
        check("por_err", 32'(frameErr), 32'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        send_frame(8'h2D, 1'b0, 1'b1, 11, -1, 1'b0);
        expect_outputs("make_2d", 8'h2D, 1'b0, 1'b0);

        send_frame(8'hF0, 1'b0, 1'b1, 11, -1, 1'b0);
        send_frame(8'h2D, 1'b0, 1'b1, 11, -1, 1'b0);
        expect_outputs("break_2d", 8'h2D, 1'b1, 1'b0);
        send_frame(8'h2D, 1'b0, 1'b1, 11, -1, 1'b0);
        expect_outputs("after_break", 8'h2D, 1'b0, 1'b0);

        send_frame(8'hE0, 1'b0, 1'b1, 11, -1, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, 11, -1, 1'b0);
        send_frame(8'h75, 1'b0, 1'b1, 11, -1, 1'b0);
        expect_outputs("ext_break_75", 8'h75, 1'b1, 1'b1);

        send_frame(8'h1C, 1'b1, 1'b1, 11, -1, 1'b0);
        expect_outputs("bad_parity_hold", 8'h75, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b0, 11, -1, 1'b0);
        expect_outputs("bad_stop_hold", 8'h75, 1'b1, 1'b1);

        send_frame(8'hE0, 1'b0, 1'b1, 11, -1, 1'b0);
        send_frame(8'h2D, 1'b0, 1'b1, 5, -1, 1'b1);
        repeat (TO + 10) @(negedge clk);
        send_frame(8'h2D, 1'b0, 1'b1, 11, -1, 1'b0);
        expect_outputs("after_timeout", 8'h2D, 1'b0, 1'b0);

        send_frame(8'h3C, 1'b0, 1'b1, 11, 4, 1'b0);
        expect_outputs("glitch_3c", 8'h3C, 1'b0, 1'b0);

        send_frame(8'h2D, 1'b0, 1'b1, 6, -1, 1'b0);
        do_reset();
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1, 1'b0);
        expect_outputs("post_reset_1c", 8'h1C, 1'b0, 1'b0);

        for (int k = 0; k < 28; k++) begin
            r  = int'($urandom_range(0, 9));
            b  = 8'($urandom);
            gb = -1;
            if (r == 0) b = 8'hF0;
            if (r == 1) b = 8'hE0;
            if (r == 4) gb = int'($urandom_range(1, 9));
            send_frame(b, r == 2, r != 3, 11, gb, 1'b0);
        end

        repeat (50) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
